// File: rtl/lut6_2_init_reader_pkg.sv
// Shared types and constants for the LUT6_2 INIT readback engine.
package lut_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int LUT_ADDR_W = 6;
  localparam int LUT_DEPTH  = 64;
  localparam int O5_HALF    = 32;
  localparam int SETTLE_W   = 4;

  // O5 is the low-half table: below O5_HALF it equals O6, above it repeats the bit captured 32 addresses earlier.
  function automatic logic o5_expected(input logic [LUT_ADDR_W-1:0] addr,
                                       input logic                  o6,
                                       input logic [LUT_DEPTH-1:0]  table_bits);
    if (int'(addr) < O5_HALF) return o6;
    return table_bits[{1'b0, addr[LUT_ADDR_W-2:0]}];
  endfunction

endpackage

// File: rtl/lut6_2_init_reader_if.sv
// Probe bus between the readback engine (master) and the LUT under test (slave).
interface lut6_2_init_reader_if;
  import lut_reader_pkg::*;

  logic [LUT_ADDR_W-1:0] I;
  logic                  O5;
  logic                  O6;

  modport master (output I, input O5, input O6);
  modport slave  (input I, output O5, output O6);

endinterface

// File: rtl/lut6_2_init_reader_sweeper.sv
// Address register and settle counter; flags the sampling cycle and the final address.
module lut_addr_sweeper
  import lut_reader_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  run,
  output logic [LUT_ADDR_W-1:0] I,
  output logic                  sample_en,
  output logic                  last
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  logic [SETTLE_W-1:0] cnt;

  assign sample_en = run && (cnt == SETTLE_LAST);
  assign last      = (I == LUT_ADDR_W'(LUT_DEPTH - 1));

  // At the last address I parks on 63; the FSM's clear returns it to 0 only when FIN is left.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      I   <= '0;
      cnt <= '0;
    end else if (sample_en) begin
      if (!last) begin
        I   <= I + 1'b1;
        cnt <= '0;
      end
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lut6_2_init_reader.sv
// Sweeps a LUT6_2 through all 64 addresses, rebuilds INIT from O6 and cross-checks O5.
module lut6_2_init_reader
  import lut_reader_pkg::*;
#(
  parameter int SETTLE         = 1,
  parameter int START_ADDR_LOG = 0
) (
  input  logic                     C,
  input  logic                     R,
  input  logic                     start,
  lut6_2_init_reader_if.master     lut,
  output logic                     busy,
  output logic                     done,
  output logic [LUT_DEPTH-1:0]     init_out,
  output logic                     init_valid,
  output logic                     o5_err,
  output logic [LUT_ADDR_W-1:0]    o5_err_idx
);

  if (SETTLE < 1 || SETTLE > 15 || START_ADDR_LOG != 0) begin : g_param_check
    $error("lut6_2_init_reader: SETTLE must be 1..15 and START_ADDR_LOG must be 0");
  end

  state_t                state;
  logic [LUT_ADDR_W-1:0] addr;
  logic                  sample_en;
  logic                  last;

  lut_addr_sweeper #(.SETTLE(SETTLE)) u_sweeper (
    .clk       (C),
    .rst       (R),
    .clear     (state != HOLD),
    .run       (state == HOLD),
    .I         (addr),
    .sample_en (sample_en),
    .last      (last)
  );

  assign lut.I = addr;

  // Only the first O5 mismatch of a sweep is latched; later ones leave the index untouched.
  always_ff @(posedge C) begin
    if (R) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      init_out   <= '0;
      init_valid <= 1'b0;
      o5_err     <= 1'b0;
      o5_err_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= HOLD;
            busy       <= 1'b1;
            init_out   <= '0;
            init_valid <= 1'b0;
            o5_err     <= 1'b0;
            o5_err_idx <= '0;
          end
        end
        HOLD: begin
          if (sample_en) begin
            init_out[addr] <= lut.O6;
            if ((lut.O5 != o5_expected(addr, lut.O6, init_out)) && !o5_err) begin
              o5_err     <= 1'b1;
              o5_err_idx <= addr;
            end
            if (last) begin
              state      <= FIN;
              busy       <= 1'b0;
              done       <= 1'b1;
              init_valid <= 1'b1;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut6_2_init_reader.sv
// Scoreboard bench: two readers (SETTLE=1 and SETTLE=3) sweeping behavioural LUT6_2 models.
module tb_lut6_2_init_reader;

  localparam int LAT_A = 65;
  localparam int LAT_B = 193;

  typedef struct {
    logic [63:0] init;
    logic        err;
    logic [5:0]  idx;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [63:0] init_a, init_b;
  logic        force0_a;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt_a = 0;
  int          done_cnt_b = 0;
  exp_t        exp_q_a[$];
  exp_t        exp_q_b[$];

  logic        busy_a, done_a, init_valid_a, o5_err_a;
  logic [63:0] init_out_a;
  logic [5:0]  o5_err_idx_a;
  logic        busy_b, done_b, init_valid_b, o5_err_b;
  logic [63:0] init_out_b;
  logic [5:0]  o5_err_idx_b;

  lut6_2_init_reader_if lut_a ();
  lut6_2_init_reader_if lut_b ();

  // LUT6_2 model: O6 spans all 64 entries, O5 only the low 32 (forceable to 0 on reader A).
  assign lut_a.O6 = init_a[lut_a.I];
  assign lut_a.O5 = force0_a ? 1'b0 : init_a[{1'b0, lut_a.I[4:0]}];
  assign lut_b.O6 = init_b[lut_b.I];
  assign lut_b.O5 = init_b[{1'b0, lut_b.I[4:0]}];

  lut6_2_init_reader #(.SETTLE(1), .START_ADDR_LOG(0)) dut_a (
    .C(clk), .R(rst), .start(start_a), .lut(lut_a),
    .busy(busy_a), .done(done_a), .init_out(init_out_a),
    .init_valid(init_valid_a), .o5_err(o5_err_a), .o5_err_idx(o5_err_idx_a)
  );

  lut6_2_init_reader #(.SETTLE(3), .START_ADDR_LOG(0)) dut_b (
    .C(clk), .R(rst), .start(start_b), .lut(lut_b),
    .busy(busy_b), .done(done_b), .init_out(init_out_b),
    .init_valid(init_valid_b), .o5_err(o5_err_b), .o5_err_idx(o5_err_idx_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic compare_done(input string tag, input exp_t e, input logic [63:0] io,
                              input logic err, input logic [5:0] idx, input logic iv,
                              input logic bsy);
    check_output({tag, "_init_out"}, io, e.init);
    check_output({tag, "_o5_err"}, 64'(err), 64'(e.err));
    check_output({tag, "_o5_err_idx"}, 64'(idx), 64'(e.idx));
    check_output({tag, "_init_valid"}, 64'(iv), 64'd1);
    check_output({tag, "_busy_at_done"}, 64'(bsy), 64'd0);
    check_output({tag, "_latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && done_a === 1'b1) begin
      done_cnt_a <= done_cnt_a + 1;
      if (exp_q_a.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL a_unexpected_done: actual=done pulse required=no done");
      end else begin
        e = exp_q_a.pop_front();
        compare_done("a", e, init_out_a, o5_err_a, o5_err_idx_a, init_valid_a, busy_a);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && done_b === 1'b1) begin
      done_cnt_b <= done_cnt_b + 1;
      if (exp_q_b.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL b_unexpected_done: actual=done pulse required=no done");
      end else begin
        e = exp_q_b.pop_front();
        compare_done("b", e, init_out_b, o5_err_b, o5_err_idx_b, init_valid_b, busy_b);
      end
    end
  end

  task automatic apply_stimulus(input bit which, input logic [63:0] init, input logic f0,
                                input logic exp_err, input logic [5:0] exp_idx);
    exp_t e;
    @(negedge clk);
    e.init = init;
    e.err  = exp_err;
    e.idx  = exp_idx;
    e.acc  = cyc + 1;
    if (which) begin
      init_b  = init;
      start_b = 1'b1;
      e.lat   = LAT_B;
      exp_q_b.push_back(e);
    end else begin
      init_a   = init;
      force0_a = f0;
      start_a  = 1'b1;
      e.lat    = LAT_A;
      exp_q_a.push_back(e);
    end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int base, input int budget);
    int n = 0;
    while (((which ? done_cnt_b : done_cnt_a) == base) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if ((which ? done_cnt_b : done_cnt_a) == base) begin
      errors++;
      $display("[TB] FAIL wait_done_%0d: actual=no done after %0d cycles required=done pulse", which, budget);
    end
  endtask

  initial begin
    int base;
    int hold_bad;
    int busy_bad;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    init_a = '0; init_b = '0; force0_a = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_I", 64'(lut_a.I), 64'd0);
    check_output("rst_busy", 64'(busy_a), 64'd0);
    check_output("rst_done", 64'(done_a), 64'd0);
    check_output("rst_init_out", init_out_a, 64'd0);
    check_output("rst_init_valid", 64'(init_valid_a), 64'd0);
    check_output("rst_o5_err", 64'(o5_err_a), 64'd0);
    check_output("rst_o5_err_idx", 64'(o5_err_idx_a), 64'd0);

    // start together with R must lose
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1;
    check_output("rst_wins_over_start", 64'(busy_a), 64'd0);
    @(negedge clk); rst = 1'b0; start_a = 1'b0;

    // basic sweep, SETTLE=1
    base = done_cnt_a;
    apply_stimulus(0, 64'hfedcba9876543210, 1'b0, 1'b0, 6'd0);
    wait_done(0, base, 200);
    #1;
    check_output("a_done_one_cycle", 64'(done_a), 64'd0);
    check_output("a_init_valid_held", 64'(init_valid_a), 64'd1);
    check_output("a_I_back_to_zero", 64'(lut_a.I), 64'd0);
    check_output("a_init_out_held", init_out_a, 64'hfedcba9876543210);

    // SETTLE=3: each address held exactly three cycles, busy for 192
    base = done_cnt_b;
    hold_bad = 0;
    busy_bad = 0;
    apply_stimulus(1, 64'hfedcba9876543210, 1'b0, 1'b0, 6'd0);
    for (int c = 0; c < 192; c++) begin
      if (lut_b.I !== 6'(c / 3)) hold_bad++;
      if (busy_b !== 1'b1) busy_bad++;
      @(posedge clk);
      #1;
    end
    wait_done(1, base, 50);
    check_output("b_I_hold_violations", 64'(hold_bad), 64'd0);
    check_output("b_busy_low_cycles", 64'(busy_bad), 64'd0);

    // O5 stuck at 0: first 1 in INIT[31:0] is bit 4
    base = done_cnt_a;
    apply_stimulus(0, 64'hfedcba9876543210, 1'b1, 1'b1, 6'd4);
    wait_done(0, base, 200);
    force0_a = 1'b0;

    // abort mid-sweep
    base = done_cnt_a;
    apply_stimulus(0, 64'h0123456789abcdef, 1'b0, 1'b0, 6'd0);
    repeat (19) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    exp_q_a.delete();
    check_output("abort_busy", 64'(busy_a), 64'd0);
    check_output("abort_I", 64'(lut_a.I), 64'd0);
    check_output("abort_init_out", init_out_a, 64'd0);
    check_output("abort_done", 64'(done_a), 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check_output("abort_no_done", 64'(done_cnt_a - base), 64'd0);
    base = done_cnt_a;
    apply_stimulus(0, 64'h0123456789abcdef, 1'b0, 1'b0, 6'd0);
    wait_done(0, base, 200);

    // starts during a sweep are dropped
    base = done_cnt_a;
    apply_stimulus(0, 64'hfedcba9876543210, 1'b0, 1'b0, 6'd0);
    repeat (3) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (24) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_done(0, base, 200);
    repeat (70) @(posedge clk);
    #1;
    check_output("ignored_start_done_count", 64'(done_cnt_a - base), 64'd1);
    check_output("ignored_start_idle", 64'(busy_a), 64'd0);

    // corner INIT, then a start in the cycle right after done
    base = done_cnt_a;
    apply_stimulus(0, 64'h8000000000000001, 1'b0, 1'b0, 6'd0);
    wait_done(0, base, 200);
    base = done_cnt_a;
    apply_stimulus(0, 64'hfedcba9876543210, 1'b0, 1'b0, 6'd0);
    check_output("b2b_init_valid_drop", 64'(init_valid_a), 64'd0);
    check_output("b2b_busy", 64'(busy_a), 64'd1);
    wait_done(0, base, 200);

    repeat (5) @(posedge clk);
    check_output("a_pending_expectations", 64'(exp_q_a.size()), 64'd0);
    check_output("b_pending_expectations", 64'(exp_q_b.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lut6_2_init_reader.md
Name: lut6_2_init_reader

Overview:
Sweep engine that reads back the truth table of an attached LUT6_2 emulator, the read-side counterpart of INIT configuration. It drives I0..I5 through addresses 0..63 and samples O6 into a reconstructed 64-bit INIT. It also cross-checks O5 against the low half of that table. It is used for self-checking regression of the LUT emulators and as an in-fabric configuration readback.

Parameters:
SETTLE, 1, cycles each address is held before O5/O6 are sampled; legal range 1..15.
START_ADDR_LOG, 0, reserved and must be 0; the sweep always starts at address 0.

Ports:
C  input  1  clock; all state changes on the rising edge.
R  input  1  synchronous active-high reset.
start  input  1  sweep request; sampled only in IDLE.
I  output  6  drive to LUT I5..I0; bit k connects to Ik.
O5  input  1  LUT O5 under test.
O6  input  1  LUT O6 under test.
busy  output  1  high while a sweep is in progress.
done  output  1  one-cycle pulse when a sweep completes.
init_out  output  64  reconstructed INIT; bit i = O6 sampled at address i.
init_valid  output  1  high from done until the next accepted start or R.
o5_err  output  1  sticky flag: an O5 mismatch was seen during the current sweep.
o5_err_idx  output  6  address of the first O5 mismatch; 0 if none.

Behaviour:
- Clocking and reset: one clock C. Reset R is synchronous and active-high.
- Values while R is high, at the next edge: state=IDLE, I=0, busy=0, done=0, init_out=0, init_valid=0, o5_err=0, o5_err_idx=0, settle counter=0.
- R mid-sweep aborts the sweep immediately. No done pulse is produced and the partial init_out is discarded (zeroed).
- States: IDLE, HOLD, FIN.
- IDLE with start=1: go to HOLD. Set I=0, cnt=0, busy=1. Clear init_out, init_valid, o5_err and o5_err_idx.
- HOLD, every cycle with cnt<SETTLE-1: cnt++.
- HOLD with cnt==SETTLE-1: sample at this edge.
  - init_out[I] <= O6.
  - O5 check: expected = O6 if I<32, else init_out[I-32].
  - If O5 != expected and o5_err==0: set o5_err=1 and o5_err_idx=I.
  - If I==63: go to FIN. Otherwise I++ and cnt=0.
- FIN: done=1 and init_valid=1 for one cycle. busy=0 in the same cycle. Next state is IDLE. I returns to 0 at that edge.
- Latency: from the start-accept edge to the done-high cycle is exactly 64*SETTLE+1 cycles.
- I is registered. With SETTLE=1, the address is presented for one full cycle before sampling, which is valid for the combinational LUT path.
- start while busy or in FIN is ignored and not queued.
- start in the same cycle as R: R wins.
- I wraps 63->0 only via FIN, never by arithmetic overflow.
- cnt is 4 bits wide. I is 6 bits wide and the increment is unsigned.
- init_out, o5_err and o5_err_idx hold their values in IDLE until the next accepted start.

Decomposition:
- Package lut_reader_pkg holds:
  - state encoding (IDLE=2'd0, HOLD=2'd1, FIN=2'd2);
  - LUT_ADDR_W=6, LUT_DEPTH=64, O5_HALF=32;
  - SETTLE_W=4.
- One sub-module is natural: lut_addr_sweeper. It contains the address register, settle counter and last-address detect. Its outputs are I, sample_en and last.
- The top module keeps the FSM, the capture register and the O5 checker.

Test Plan:
- LUT6_2 INIT=64'hfedcba9876543210, SETTLE=1, pulse start -> done at cycle 65 after accept, init_out=64'hfedcba9876543210, o5_err=0, init_valid=1.
- Same INIT, SETTLE=3 -> busy high 192 cycles, done at cycle 193, same init_out; I holds each address for exactly 3 cycles.
- O5 forced 0 with INIT=64'hfedcba9876543210 -> o5_err=1 and o5_err_idx=4 (first 1 in INIT[31:0]); init_out still correct.
- R asserted at cycle 20 of the sweep -> next cycle busy=0, I=0, init_out=0; no done pulse; a new start then completes normally.
- start pulsed at cycles 5 and 30 of a sweep -> ignored; exactly one done. Back-to-back start in the cycle after done -> accepted, and init_valid drops.
- INIT=64'h8000000000000001 -> init_out matches; o5_err=0.
